wavetable_voice_bank: RTL and testbench
=======================================

// Module: wavetable_voice_bank
// PURPOSE
//  N-voice wavetable oscillator bank, successor to the 2-voice PWM sample player.
//  Each voice steps an index through a 2^IDX_W-entry single-cycle wave table every (divider+1) clocks.
//  Voices share one external synchronous ROM through a round-robin slot scheduler, one lookup per clock.
//  Per-voice samples plus a summed mix feed the downstream PWM/DAC stage.
// PARAMETERS
//  NUM_VOICES  4   number of voices (>=2); slot counter width SLOT_W = $clog2(NUM_VOICES)
//  DIV_W       12  divider width; step period = divider+1 clocks
//  IDX_W       8   table index width (table depth 2^IDX_W)
//  SAMPLE_W    8   unsigned sample width; mix width MIX_W = SAMPLE_W+SLOT_W
// PORTS
//  clk         in   1                    clock; one clock domain
//  rst         in   1                    reset: asynchronous, active-high
//  divider     in   NUM_VOICES*DIV_W     per-voice divider, voice v at [v*DIV_W +: DIV_W]
//  voice_en    in   NUM_VOICES           per-voice run enable
//  rom_addr    out  IDX_W                table address for the current slot (combinational from slot)
//  rom_data    in   SAMPLE_W             table data, valid 1 clock after rom_addr
//  sample      out  NUM_VOICES*SAMPLE_W  latest sample per voice, voice v at [v*SAMPLE_W +: SAMPLE_W]
//  sample_upd  out  NUM_VOICES           1-clock pulse: sample[v] written this clock
//  mix         out  MIX_W                sum of enabled voices' samples over the last round
//  mix_valid   out  1                    1-clock pulse when mix is updated
//  retrig      in   NUM_VOICES           per-voice retrigger (only with WAVETABLE_RETRIG_EN)
// BEHAVIOUR
//  Reset (async, rst=1): count[v]=0, idx[v]=0, slot=0, rd_valid=0, acc=0, sample=0, sample_upd=0, mix=0, mix_valid=0.
//  Step counters, every clock, each voice independently:
//   - voice_en[v]=0: count[v] and idx[v] hold.
//   - voice_en[v]=1, count[v]!=0: count[v] <= count[v]-1.
//   - voice_en[v]=1, count[v]==0: count[v] <= divider[v]; idx[v] <= idx[v]+1 (wraps 2^IDX_W-1 -> 0).
//   - divider=0 steps every clock; divider changes take effect at the next reload only.
//  Scheduler: slot cycles 0..NUM_VOICES-1, wraps to 0; advances every clock regardless of voice_en.
//   - rom_addr = idx[slot] (value before this clock's step update).
//   - Pipeline regs rd_slot<=slot, rd_en<=voice_en[slot], rd_valid<=1 (0 only first clock after reset).
//  Capture (rd_valid=1): sample[rd_slot] <= rom_data; sample_upd[rd_slot]=1 for that clock.
//   - Disabled voices are still sampled (frozen index), but contribute 0 to the mix.
//  Latency: rom_addr for slot s at clock t -> sample[s] visible after edge t+1. Round = NUM_VOICES clocks.
//  Mix (MIX_W-bit, cannot overflow): term = rd_en ? rom_data : 0.
//   - rd_valid && rd_slot!=NUM_VOICES-1: acc <= acc + term.
//   - rd_valid && rd_slot==NUM_VOICES-1: mix <= acc + term; acc <= 0; mix_valid=1 for one clock.
//   - First mix_valid: NUM_VOICES+1 clock edges after rst deasserts.
//  rst asserted mid-round: all state cleared immediately; partial acc discarded, no mix_valid.
//  rst asserted during a ROM read: data is ignored (rd_valid=0).
// CONFIGURATION
//  WAVETABLE_RETRIG_EN defined: retrig[v]=1 in a clock forces idx[v]<=0, count[v]<=divider[v].
//   - Overrides the step rule and voice_en; a retrig on the same clock as a reload wins.
//  WAVETABLE_RETRIG_EN undefined: retrig port is present but ignored; no retrigger logic is built.
// TESTING
//  T1 reset: rst=1 mid-round -> all outputs 0 within the same clock; after release, slot restarts at 0 and first mix_valid occurs NUM_VOICES+1 edges later.
//  T2 stepping: NUM_VOICES=4, voice 0 divider=3, en=1 -> idx[0] increments every 4 clocks; 0xFF -> 0x00 wrap observed on rom_addr.
//  T3 divider=0 on all voices, rom_data=rom_addr (identity table) -> rom_addr advances by 1 per clock on each voice; sample[v] tracks it.
//  T4 mix: voice_en=4'b0101, rom_data=8'd200 constant -> mix=400 each round; voice_en=4'b1111 at 255 -> mix=1020, no overflow.
//  T5 disable: voice_en[2] 1->0 -> idx[2] frozen, sample_upd[2] still pulses once per round, mix excludes voice 2.
//  T6 (WAVETABLE_RETRIG_EN) retrig[1] pulse at idx[1]=0x37 with voice_en[1]=0 -> idx[1]=0 next clock, count[1]=divider[1]; without macro -> no effect.

Source files
------------

// File: rtl/wavetable_voice_bank.sv
// wavetable_voice_bank
// N-voice wavetable oscillator bank. Each voice steps a table index every
// (divider+1) clocks. The voices share one external synchronous ROM through
// a round-robin slot scheduler that issues one lookup per clock. Per-voice
// samples and a per-round mix of the enabled voices feed the PWM/DAC stage.
// Optional feature: define WAVETABLE_RETRIG_EN to build per-voice retrigger
// logic. Without it the retrig port exists but is ignored.

module wavetable_voice_bank #(
   parameter int NUM_VOICES = 4,
   parameter int DIV_W      = 12,
   parameter int IDX_W      = 8,
   parameter int SAMPLE_W   = 8,
   localparam int SLOT_W    = $clog2(NUM_VOICES),
   localparam int MIX_W     = SAMPLE_W + SLOT_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_VOICES*DIV_W-1:0]    divider,
   input  logic [NUM_VOICES-1:0]          voice_en,
   output logic [IDX_W-1:0]               rom_addr,
   input  logic [SAMPLE_W-1:0]            rom_data,
   output logic [NUM_VOICES*SAMPLE_W-1:0] sample,
   output logic [NUM_VOICES-1:0]          sample_upd,
   output logic [MIX_W-1:0]               mix,
   output logic                           mix_valid,
   input  logic [NUM_VOICES-1:0]          retrig
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

   logic [DIV_W-1:0]  count [NUM_VOICES];
   logic [IDX_W-1:0]  idx   [NUM_VOICES];
   logic [SLOT_W-1:0] slot;
   logic [SLOT_W-1:0] rd_slot;
   logic              rd_en;
   logic              rd_valid;
   logic [MIX_W-1:0]  acc;
   logic [MIX_W-1:0]  term;

`ifndef WAVETABLE_RETRIG_EN
   logic unused_retrig;
   assign unused_retrig = ^retrig;
`endif

   // Per-voice step counters: reload and advance the index when the count expires
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            count[v] <= '0;
            idx[v]   <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
`ifdef WAVETABLE_RETRIG_EN
            if (retrig[v]) begin
               idx[v]   <= '0;
               count[v] <= divider[v*DIV_W +: DIV_W];
            end else
`endif
            if (voice_en[v]) begin
               if (count[v] == '0) begin
                  count[v] <= divider[v*DIV_W +: DIV_W];
                  idx[v]   <= idx[v] + IDX_W'(1);
               end else begin
                  count[v] <= count[v] - DIV_W'(1);
               end
            end
         end
      end
   end

   // The ROM address always shows the index of the voice owning the current slot
   assign rom_addr = idx[slot];

   // Round-robin slot counter plus the one-deep pipeline that tracks the ROM read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot     <= '0;
         rd_slot  <= '0;
         rd_en    <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         slot     <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
         rd_slot  <= slot;
         rd_en    <= voice_en[slot];
         rd_valid <= 1'b1;
      end
   end

   // Capture returning ROM data into the owning voice's sample and flag the update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample     <= '0;
         sample_upd <= '0;
      end else begin
         sample_upd <= '0;
         if (rd_valid) begin
            sample[rd_slot*SAMPLE_W +: SAMPLE_W] <= rom_data;
            sample_upd[rd_slot]                  <= 1'b1;
         end
      end
   end

   // Disabled voices are still read but add nothing to the mix
   assign term = rd_en ? MIX_W'(rom_data) : '0;

   // Accumulate one round of terms and publish the total after the last slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         mix       <= '0;
         mix_valid <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (rd_valid) begin
            if (rd_slot == LAST_SLOT) begin
               mix       <= acc + term;
               acc       <= '0;
               mix_valid <= 1'b1;
            end else begin
               acc <= acc + term;
            end
         end
      end
   end

endmodule

// File: tb/tb_wavetable_voice_bank.sv
// tb_wavetable_voice_bank
// Directed bench for wavetable_voice_bank with a synchronous ROM model that
// returns either a constant or its own address. Expected values are worked
// out by hand from the step, scheduler and mix rules. Retrigger expectations
// follow WAVETABLE_RETRIG_EN.

module tb_wavetable_voice_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] divider;
   logic [3:0]  voice_en;
   logic [3:0]  retrig;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [31:0] sample;
   logic [3:0]  sample_upd;
   logic [9:0]  mix;
   logic        mix_valid;

   bit          romIdentity;
   logic [7:0]  romConst;

   int passCount  = 0;
   int checkCount = 0;

   wavetable_voice_bank dut (
      .clk        (clk),
      .rst        (rst),
      .divider    (divider),
      .voice_en   (voice_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .sample     (sample),
      .sample_upd (sample_upd),
      .mix        (mix),
      .mix_valid  (mix_valid),
      .retrig     (retrig)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Synchronous ROM model: data appears one clock after the address
   always @(posedge clk) begin
      rom_data <= romIdentity ? rom_addr : romConst;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reset the DUT with a new configuration, then release it just after an edge
   task automatic applyStimulus(input logic [47:0] div, input logic [3:0] en,
                                input bit ident, input logic [7:0] cval);
      rst         = 1'b1;
      divider     = div;
      voice_en    = en;
      retrig      = 4'b0000;
      romIdentity = ident;
      romConst    = cval;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      // T1/T2: reset values, pipeline latency, voice 0 stepping every 4 clocks
      rst         = 1'b1;
      divider     = {12'd0, 12'd0, 12'd0, 12'd3};
      voice_en    = 4'b0001;
      retrig      = 4'b0000;
      romIdentity = 1'b0;
      romConst    = 8'd10;
      tick(2);
      checkOutput("rst_sample", sample, 32'h0);
      checkOutput("rst_upd", sample_upd, 4'h0);
      checkOutput("rst_mix", mix, 10'd0);
      checkOutput("rst_mix_valid", mix_valid, 1'b0);
      checkOutput("rst_rom_addr", rom_addr, 8'h00);
      rst = 1'b0;
      checkOutput("t2_addr_e0", rom_addr, 8'h00);
      tick(4);
      checkOutput("t1_no_mix_e4", mix_valid, 1'b0);
      checkOutput("t2_addr_e4", rom_addr, 8'h01);
      tick(1);
      checkOutput("t1_mix_valid_e5", mix_valid, 1'b1);
      checkOutput("t1_mix_e5", mix, 10'd10);
      checkOutput("t1_sample_e5", sample, 32'h0A0A0A0A);
      checkOutput("t1_upd_e5", sample_upd, 4'b1000);
      tick(1);
      checkOutput("t1_mix_valid_e6", mix_valid, 1'b0);
      checkOutput("t1_upd_e6", sample_upd, 4'b0001);
      tick(1014);
      checkOutput("t2_addr_ff", rom_addr, 8'hFF);
      tick(4);
      checkOutput("t2_addr_wrap", rom_addr, 8'h00);
      tick(1);
      checkOutput("t2_addr_v1_frozen", rom_addr, 8'h00);
      tick(1);
      checkOutput("t1_mix_before_rst", mix, 10'd10);

      // T1: reset in the middle of a round clears everything at once
      rst = 1'b1;
      #1;
      checkOutput("t1_mid_sample", sample, 32'h0);
      checkOutput("t1_mid_mix", mix, 10'd0);
      checkOutput("t1_mid_upd", sample_upd, 4'h0);
      checkOutput("t1_mid_rom_addr", rom_addr, 8'h00);
      tick(1);
      rst = 1'b0;
      tick(4);
      checkOutput("t1_rel_no_mix_e4", mix_valid, 1'b0);
      tick(1);
      checkOutput("t1_rel_mix_valid_e5", mix_valid, 1'b1);
      checkOutput("t1_rel_mix_e5", mix, 10'd10);

      // T3: divider 0 on every voice with an identity table
      applyStimulus(48'h0, 4'b1111, 1'b1, 8'd0);
      tick(1);
      checkOutput("t3_addr_e1", rom_addr, 8'd1);
      tick(1);
      checkOutput("t3_addr_e2", rom_addr, 8'd2);
      tick(3);
      checkOutput("t3_mix_e5", mix, 10'd6);
      checkOutput("t3_mix_valid_e5", mix_valid, 1'b1);
      tick(4);
      checkOutput("t3_mix_e9", mix, 10'd22);
      tick(1);
      checkOutput("t3_sample_e10", sample, 32'h07060508);
      checkOutput("t3_addr_e10", rom_addr, 8'd10);

      // T4: mix of two voices, then all four at full scale
      applyStimulus(48'h0, 4'b0101, 1'b0, 8'd200);
      tick(5);
      checkOutput("t4_mix_e5", mix, 10'd400);
      tick(4);
      checkOutput("t4_mix_e9", mix, 10'd400);
      voice_en = 4'b1111;
      romConst = 8'd255;
      tick(8);
      checkOutput("t4_mix_full", mix, 10'd1020);
      checkOutput("t4_mix_valid_full", mix_valid, 1'b1);

      // T5: disabling voice 2 freezes its index but keeps it sampled
      applyStimulus(48'h0, 4'b1111, 1'b1, 8'd0);
      tick(6);
      checkOutput("t5_addr_e6", rom_addr, 8'd6);
      voice_en = 4'b1011;
      tick(4);
      checkOutput("t5_addr_v2_e10", rom_addr, 8'd6);
      tick(1);
      checkOutput("t5_addr_v3_e11", rom_addr, 8'd11);
      tick(1);
      checkOutput("t5_upd_v2_e12", sample_upd, 4'b0100);
      tick(1);
      checkOutput("t5_mix_e13", mix, 10'd28);
      checkOutput("t5_sample_e13", sample, 32'h0B060908);
      tick(1);
      checkOutput("t5_addr_v2_e14", rom_addr, 8'd6);

      // T6: retrigger a disabled voice sitting at index 0x37
      applyStimulus(48'h0, 4'b1111, 1'b1, 8'd0);
      tick(55);
      voice_en = 4'b1101;
      tick(1);
      retrig = 4'b0010;
      tick(1);
      retrig = 4'b0000;
`ifdef WAVETABLE_RETRIG_EN
      checkOutput("t6_retrig_e57", rom_addr, 8'h00);
`else
      checkOutput("t6_retrig_e57", rom_addr, 8'h37);
`endif
      tick(3);
      checkOutput("t6_addr_v0_e60", rom_addr, 8'd60);
      tick(1);
`ifdef WAVETABLE_RETRIG_EN
      checkOutput("t6_retrig_e61", rom_addr, 8'h00);
`else
      checkOutput("t6_retrig_e61", rom_addr, 8'h37);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
